// File: rtl/mux_pipe_pkg.sv
// Shared definitions for mux_pipe: default parameters, counter width,
// output-register occupancy encoding and the channel-slice index helper.
package mux_pipe_pkg;

  localparam int unsigned XFER_CNT_W     = 32;
  localparam int unsigned MUX_PIPE_N     = 4;
  localparam int unsigned MUX_PIPE_WIDTH = 32;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  // Lowest bit of channel k inside the packed N*WIDTH input bus.
  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/mux_pipe_if.sv
// Handshake bundle between an upstream producer (master) and a mux_pipe
// stage (slave): input words with select, registered output word and debug count.
interface mux_pipe_if
  import mux_pipe_pkg::*;
#(
  parameter int unsigned N     = MUX_PIPE_N,
  parameter int unsigned WIDTH = MUX_PIPE_WIDTH
);
  localparam int unsigned SEL_W = $clog2(N);

  logic                  in_valid;
  logic                  in_ready;
  logic [N*WIDTH-1:0]    in_data;
  logic [SEL_W-1:0]      sel;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_err;
  logic [XFER_CNT_W-1:0] xfer_cnt;

  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_err, xfer_cnt
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_err, xfer_cnt
  );

endinterface

// File: rtl/mux_pipe_sel.sv
// Combinational N:1 WIDTH-bit word select with range check; an out-of-range
// select yields an all-zero word and raises err_o.
module mux_pipe_sel
  import mux_pipe_pkg::*;
#(
  parameter int unsigned N     = MUX_PIPE_N,
  parameter int unsigned WIDTH = MUX_PIPE_WIDTH,
  parameter int unsigned SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   word_o,
  output logic               err_o
);

  always_comb begin
    // NOTE: defaults first so every path assigns each output and no latch is inferred.
    word_o = '0;
    err_o  = (32'(sel_i) >= N);
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) word_o = data_i[chan_lsb(k, WIDTH) +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_pipe.sv
// Registered N:1 select stage with valid/ready handshake and transfer counter.
// Define MUX_PIPE_SKID_EN for a one-entry skid register and a registered in_ready.
module mux_pipe
  import mux_pipe_pkg::*;
#(
  parameter int unsigned N     = MUX_PIPE_N,
  parameter int unsigned WIDTH = MUX_PIPE_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_pipe_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(N);

  occ_e                  state_q, state_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_sel_q, out_sel_d;
  logic                  out_err_q, out_err_d;
  logic [XFER_CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [WIDTH-1:0] mux_word;
  logic             mux_err;
  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             xfer;
  logic             load_fresh;

  mux_pipe_sel #(
    .N     (N),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_sel (
    .data_i (bus.in_data),
    .sel_i  (bus.sel),
    .word_o (mux_word),
    .err_o  (mux_err)
  );

  assign out_valid = (state_q != OCC_EMPTY);
  assign accept    = bus.in_valid && in_ready;
  assign xfer      = out_valid && bus.out_ready;

`ifdef MUX_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_data_q;
  logic [SEL_W-1:0] skid_sel_q;
  logic             skid_err_q;
  logic             skid_load;
  logic             in_ready_q;

  assign in_ready  = in_ready_q;
  assign skid_load = (state_q == OCC_FULL) && accept && !xfer;

  // NOTE: skid payload has no reset; state_q alone says whether it holds a word.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_q <= mux_word;
      skid_sel_q  <= bus.sel;
      skid_err_q  <= mux_err;
    end
  end
`else
  assign in_ready = rst_n && (!out_valid || bus.out_ready);
`endif

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    out_err_d  = out_err_q;
    load_fresh = 1'b0;
    xfer_cnt_d = xfer ? xfer_cnt_q + XFER_CNT_W'(1) : xfer_cnt_q;

    unique case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          load_fresh = 1'b1;
          state_d    = OCC_FULL;
        end
      end
      OCC_FULL: begin
        if (accept && xfer) load_fresh = 1'b1;
`ifdef MUX_PIPE_SKID_EN
        else if (accept) state_d = OCC_SKID;
`endif
        else if (xfer) state_d = OCC_EMPTY;
      end
`ifdef MUX_PIPE_SKID_EN
      // Draining the output promotes the parked word; input reopens next cycle.
      OCC_SKID: begin
        if (xfer) begin
          state_d    = OCC_FULL;
          out_data_d = skid_data_q;
          out_sel_d  = skid_sel_q;
          out_err_d  = skid_err_q;
        end
      end
`endif
      default: state_d = OCC_EMPTY;
    endcase

    if (load_fresh) begin
      out_data_d = mux_word;
      out_sel_d  = bus.sel;
      out_err_d  = mux_err;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= '0;
      out_err_q  <= 1'b0;
      xfer_cnt_q <= '0;
`ifdef MUX_PIPE_SKID_EN
      in_ready_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      out_err_q  <= out_err_d;
      xfer_cnt_q <= xfer_cnt_d;
`ifdef MUX_PIPE_SKID_EN
      in_ready_q <= (state_d != OCC_SKID);
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_err   = out_err_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_mux_pipe.sv
// Self-checking bench for mux_pipe: vector tables, hand-written corner sequences
// and a randomized run against a queue-based reference model.
module tb_mux_pipe;

`ifdef MUX_PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int CAP = SKID ? 2 : 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_pipe_if #(.N(4), .WIDTH(32)) bus4 ();
  mux_pipe_if #(.N(3), .WIDTH(8))  bus3 ();

  mux_pipe #(.N(4), .WIDTH(32)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  mux_pipe #(.N(3), .WIDTH(8))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        err;
  } word_t;

  typedef struct packed {
    logic        in_valid;
    logic [1:0]  sel;
    logic        out_ready;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec3_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  word_t       q[$];
  word_t       got[$];
  logic [31:0] exp_cnt = '0;

  localparam logic [127:0] CHANS = {32'hA5A5A5A5, 32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of dut4: sample handshake before the edge, update the model,
  // check the outputs just after the edge, return on the falling edge.
  task automatic cycle4(output bit acc);
    bit    xfer;
    bit    rst_at_edge;
    word_t w;
    word_t o;
    #1;
    acc         = bus4.in_valid && bus4.in_ready;
    xfer        = bus4.out_valid && bus4.out_ready;
    rst_at_edge = rst_n;
    w.sel       = bus4.sel;
    w.err       = 1'b0;
    w.data      = 32'(bus4.in_data >> (32 * int'(bus4.sel)));
    o.data      = bus4.out_data;
    o.sel       = bus4.out_sel;
    o.err       = bus4.out_err;
    @(posedge clk);
    #1;
    if (!rst_at_edge) begin
      q.delete();
      exp_cnt = '0;
      acc     = 1'b0;
    end else begin
      if (xfer) begin
        got.push_back(o);
        if (q.size() != 0) void'(q.pop_front());
        exp_cnt++;
      end
      if (acc) q.push_back(w);
    end
    check("out_valid", bus4.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", bus4.out_data, q[0].data);
      check("out_sel", bus4.out_sel, q[0].sel);
      check("out_err", bus4.out_err, q[0].err);
    end
    check("xfer_cnt", bus4.xfer_cnt, exp_cnt);
    check("in_ready", bus4.in_ready,
          SKID ? (rst_at_edge && q.size() < 2) : (rst_n && (q.size() == 0 || bus4.out_ready)));
    check("occupancy", q.size() <= CAP, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit          acc;
    int          idx;
    vec_t        tbl[5];
    vec3_t       tbl3[4];
    logic [1:0]  bp_sel[3];
    logic [31:0] bp_exp[3];
    logic [31:0] wrap_exp[4];

    tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 32'hAAAAAAAA, 2'd0, 32'd0};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h00000000, 2'd1, 32'd1};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 2'd2, 32'd2};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'hA5A5A5A5, 2'd3, 32'd3};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000000, 2'd0, 32'd4};
    tbl3[0] = '{2'd0, 8'h11, 1'b0};
    tbl3[1] = '{2'd1, 8'h22, 1'b0};
    tbl3[2] = '{2'd2, 8'h33, 1'b0};
    tbl3[3] = '{2'd3, 8'h00, 1'b1};
    bp_sel   = '{2'd2, 2'd3, 2'd1};
    bp_exp   = '{32'hFFFFFFFF, 32'hA5A5A5A5, 32'h00000000};
    wrap_exp = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.sel       = '0;
    bus4.in_data   = CHANS;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = 1'b0;
    bus3.sel       = '0;
    bus3.in_data   = {8'h33, 8'h22, 8'h11};
    bus3.out_ready = 1'b1;

    // Reset state
    repeat (2) cycle4(acc);
    check("rst_out_valid", bus4.out_valid, 1'b0);
    check("rst_out_data", bus4.out_data, 32'h0);
    check("rst_out_sel", bus4.out_sel, 2'd0);
    check("rst_out_err", bus4.out_err, 1'b0);
    check("rst_xfer_cnt", bus4.xfer_cnt, 32'h0);
    check("rst_in_ready", bus4.in_ready, 1'b0);

    rst_n          = 1'b1;
    bus4.out_ready = 1'b1;
    cycle4(acc);
    check("release_in_ready", bus4.in_ready, 1'b1);

    // Basic pass-through
    for (int i = 0; i < 5; i++) begin
      bus4.in_valid  = tbl[i].in_valid;
      bus4.sel       = tbl[i].sel;
      bus4.out_ready = tbl[i].out_ready;
      cycle4(acc);
      check($sformatf("pass_valid[%0d]", i), bus4.out_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        check($sformatf("pass_data[%0d]", i), bus4.out_data, tbl[i].exp_data);
        check($sformatf("pass_sel[%0d]", i), bus4.out_sel, tbl[i].exp_sel);
      end
      check($sformatf("pass_cnt[%0d]", i), bus4.xfer_cnt, tbl[i].exp_cnt);
    end

    // Backpressure: stream 2,3,1 with out_ready low for three cycles
    got.delete();
    idx = 0;
    for (int c = 0; c < 12 && (idx < 3 || q.size() != 0); c++) begin
      bus4.out_ready = (c >= 3);
      bus4.in_valid  = (idx < 3);
      bus4.sel       = (idx < 3) ? bp_sel[idx] : 2'd0;
      #1;
      if (c == 1) check("bp_in_ready_c1", bus4.in_ready, SKID);
      if (c == 2) check("bp_in_ready_c2", bus4.in_ready, 1'b0);
      cycle4(acc);
      if (acc) idx++;
    end
    check("bp_all_accepted", idx, 3);
    check("bp_delivered", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) check($sformatf("bp_word[%0d]", i), got[i].data, bp_exp[i]);

    // Reset mid-stream while the stage is as full as it gets
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 1'b1;
    bus4.sel       = 2'd0;
    cycle4(acc);
    bus4.sel = 2'd1;
    cycle4(acc);
    check("rst_mid_occupancy", q.size(), CAP);
    rst_n    = 1'b0;
    bus4.sel = 2'd2;
    #1;
    check("rst_mid_in_ready_low", bus4.in_ready, 1'b0);
    cycle4(acc);
    check("rst_mid_out_valid", bus4.out_valid, 1'b0);
    check("rst_mid_out_data", bus4.out_data, 32'h0);
    check("rst_mid_out_sel", bus4.out_sel, 2'd0);
    check("rst_mid_out_err", bus4.out_err, 1'b0);
    check("rst_mid_xfer_cnt", bus4.xfer_cnt, 32'h0);
    check("rst_mid_in_ready", bus4.in_ready, 1'b0);
    rst_n          = 1'b1;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    got.delete();
    cycle4(acc);
    check("rst_mid_release_ready", bus4.in_ready, 1'b1);
    repeat (3) cycle4(acc);
    check("rst_mid_no_stale", got.size(), 0);

    // Counter wrap
    dut4.xfer_cnt_q = 32'hFFFFFFFE;
    exp_cnt         = 32'hFFFFFFFE;
    for (int k = 0; k < 4; k++) begin
      bus4.in_valid  = (k < 3);
      bus4.sel       = 2'(k);
      bus4.out_ready = 1'b1;
      cycle4(acc);
      check($sformatf("wrap_cnt[%0d]", k), bus4.xfer_cnt, wrap_exp[k]);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      bus4.in_valid  = ($urandom_range(3) != 0);
      bus4.sel       = 2'($urandom_range(3));
      bus4.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus4.out_ready = ($urandom_range(2) != 0);
      cycle4(acc);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    repeat (3) cycle4(acc);
    check("drain_empty", q.size(), 0);

    // Idle input carrying X
    bus4.sel     = 'x;
    bus4.in_data = 'x;
    repeat (4) begin
      cycle4(acc);
      check("idle_no_x",
            $isunknown({bus4.out_valid, bus4.out_data, bus4.out_sel, bus4.out_err, bus4.xfer_cnt}),
            1'b0);
    end
    bus4.sel     = '0;
    bus4.in_data = CHANS;

    // Out-of-range select on a 3-channel stage
    for (int i = 0; i < 4; i++) begin
      bus3.in_valid = 1'b1;
      bus3.sel      = tbl3[i].sel;
      @(posedge clk);
      #1;
      check($sformatf("n3_valid[%0d]", i), bus3.out_valid, 1'b1);
      check($sformatf("n3_data[%0d]", i), bus3.out_data, tbl3[i].exp_data);
      check($sformatf("n3_sel[%0d]", i), bus3.out_sel, tbl3[i].sel);
      check($sformatf("n3_err[%0d]", i), bus3.out_err, tbl3[i].exp_err);
      check($sformatf("n3_cnt[%0d]", i), bus3.xfer_cnt, 32'(i));
      @(negedge clk);
    end
    bus3.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("n3_idle_valid", bus3.out_valid, 1'b0);
    check("n3_final_cnt", bus3.xfer_cnt, 32'd4);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
